// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: coefficient and butterfly-pair encodings.
package ntt_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int BFLY_W     = 2 * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] coeff_t;

  typedef struct packed {
    coeff_t x;
    coeff_t y;
  } bfly_t;

endpackage

// File: rtl/mod_addsub.sv
// Modular add/subtract pair X = (x + t) mod q, Y = (x - t) mod q for operands already < q.
module mod_addsub #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] t_i,
  input  logic [W-1:0] q_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o
);

  logic [W:0] sum_s;
  logic [W:0] dif_s;

  // One extra bit holds the carry of x + t and the borrow of x - t.
  always_comb begin
    sum_s = {1'b0, x_i} + {1'b0, t_i};
    dif_s = {1'b0, x_i} - {1'b0, t_i};
    if (sum_s >= {1'b0, q_i}) begin
      x_o = W'(sum_s - {1'b0, q_i});
    end else begin
      x_o = sum_s[W-1:0];
    end
    if (x_i < t_i) begin
      y_o = W'(dif_s + {1'b0, q_i});
    end else begin
      y_o = dif_s[W-1:0];
    end
  end

endmodule

// File: rtl/ntt_butterfly_stage.sv
// Cooley-Tukey butterfly around a fixed-latency modular multiplier, with credit-based
// admission and an output FIFO so that a non-stallable multiplier still gives lossless flow.
module ntt_butterfly_stage
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int MUL_LAT    = 1,
  parameter int OUT_DEPTH  = MUL_LAT + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  input  logic [DATA_WIDTH-1:0] in_w,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + MUL_LAT + 1);
  localparam int EW    = 2 * DATA_WIDTH;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(OUT_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [MUL_LAT-1:0]    vld_q;
  logic [DATA_WIDTH-1:0] x_q [MUL_LAT];
  logic                  started_q;
  logic [EW-1:0]         fifo_q [OUT_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [CNT_W-1:0]      inflight;
  logic                  fire_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] bf_x;
  logic [DATA_WIDTH-1:0] bf_y;

  assign mul_a   = in_y;
  assign mul_b   = in_w;
  assign fire_in = in_valid & in_ready;
  assign push    = vld_q[MUL_LAT-1];
  assign pop     = out_valid & out_ready;

  assign out_valid = (occ_q != '0);
  assign out_x     = fifo_q[rd_ptr_q][EW-1:DATA_WIDTH];
  assign out_y     = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];

  // Credits: every accepted beat is reserved a FIFO slot; a same-cycle pop is deliberately ignored.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      inflight = inflight + CNT_W'(vld_q[k]);
    end
    in_ready = started_q & ((occ_q + inflight) < CNT_W'(OUT_DEPTH));
  end

  mod_addsub #(
    .W (DATA_WIDTH)
  ) u_addsub (
    .x_i (x_q[MUL_LAT-1]),
    .t_i (mul_result),
    .q_i (modulus),
    .x_o (bf_x),
    .y_o (bf_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= 1'b0;
      vld_q     <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      started_q <= 1'b1;
      vld_q[0]  <= fire_in;
      x_q[0]    <= in_x;
      for (int k = 1; k < MUL_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        x_q[k]   <= x_q[k-1];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Entries are cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int e = 0; e < OUT_DEPTH; e++) begin
        fifo_q[e] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= {bf_x, bf_y};
      end
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_stage.sv
// Scoreboard bench for ntt_butterfly_stage with a behavioural 1-cycle modular multiplier.
module tb_ntt_butterfly_stage;

  localparam int DW        = 8;
  localparam int MUL_LAT   = 1;
  localparam int OUT_DEPTH = 3;
  localparam int Q         = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] modulus;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x, in_y, in_w;
  logic [DW-1:0] mul_a, mul_b;
  logic [DW-1:0] mul_result = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_x, out_y;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [2*DW-1:0] exp_q[$];
  logic            stall_seen = 1'b0;
  logic [2*DW-1:0] stall_val  = '0;
  logic            toggle_done;

  always #5 clk = ~clk;

  ntt_butterfly_stage #(
    .DATA_WIDTH (DW),
    .MUL_LAT    (MUL_LAT),
    .OUT_DEPTH  (OUT_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .modulus    (modulus),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_w       (in_w),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y)
  );

  always @(posedge clk) begin
    mul_result <= DW'((int'(mul_a) * int'(mul_b)) % Q);
  end

  function automatic logic [2*DW-1:0] model(input int x, input int y, input int w);
    int t, bx, by;
    t  = (y * w) % Q;
    bx = (x + t) % Q;
    by = (x + Q - t) % Q;
    return {DW'(bx), DW'(by)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      stall_seen = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(int'(in_x), int'(in_y), int'(in_w)));
      if (stall_seen && out_valid) begin
        checks++;
        if ({out_x, out_y} !== stall_val) begin
          failures++;
          $display("FAIL stall_stable: got %h want %h", {out_x, out_y}, stall_val);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        pops++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got %h want none", {out_x, out_y});
        end else begin
          logic [2*DW-1:0] e;
          e = exp_q.pop_front();
          if ({out_x, out_y} !== e) begin
            failures++;
            $display("FAIL scoreboard: got x=%0d y=%0d want x=%0d y=%0d", out_x, out_y, e[2*DW-1:DW], e[DW-1:0]);
          end
        end
      end
      stall_seen = out_valid && !out_ready;
      stall_val  = {out_x, out_y};
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(dut.push && dut.occ_q == OUT_DEPTH && !dut.pop))
  else begin
    failures++;
    $display("FAIL overflow: push into full FIFO");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic drive_beat(input int x, input int y, input int w, output int waits);
    bit done;
    in_x = DW'(x); in_y = DW'(y); in_w = DW'(w);
    in_valid = 1'b1;
    waits = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 500) begin
          failures++;
          $display("FAIL accept_timeout: got in_ready=0 want 1");
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; modulus = DW'(Q);
    in_x = '0; in_y = '0; in_w = '0;
    #2;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({out_x, out_y} !== '0) begin failures++; $display("FAIL reset_out_data: got %h want 0", {out_x, out_y}); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early: got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int w;
    drive_beat(5, 3, 4, w);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_early: got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    checks++; if (out_x !== 8'd0 || out_y !== 8'd10) begin failures++; $display("FAIL basic_data: got x=%0d y=%0d want x=0 y=10", out_x, out_y); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_single: got %b want 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_borrow();
    int vec [2][5] = '{'{16, 16, 1, 15, 0}, '{0, 1, 1, 1, 16}};
    int w;
    for (int i = 0; i < 2; i++) begin
      drive_beat(vec[i][0], vec[i][1], vec[i][2], w);
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || int'(out_x) != vec[i][3] || int'(out_y) != vec[i][4]) begin
        failures++;
        $display("FAIL borrow_%0d: got v=%b x=%0d y=%0d want v=1 x=%0d y=%0d", i, out_valid, out_x, out_y, vec[i][3], vec[i][4]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int total_waits = 0;
    int w;
    int pops0 = pops;
    for (int i = 0; i < 20; i++) begin
      drive_beat($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1), w);
      total_waits += w;
    end
    checks++; if (total_waits != 0) begin failures++; $display("FAIL b2b_in_ready: got %0d stalls want 0", total_waits); end
    repeat (3) @(posedge clk); #1;
    checks++; if (pops - pops0 != 20) begin failures++; $display("FAIL b2b_count: got %0d want 20", pops - pops0); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_x = DW'($urandom_range(0, Q-1)); in_y = DW'($urandom_range(0, Q-1)); in_w = DW'($urandom_range(0, Q-1));
      @(negedge clk);
      if (in_ready) accepted++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (accepted != OUT_DEPTH) begin failures++; $display("FAIL bp_accepted: got %0d want %0d", accepted, OUT_DEPTH); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    drain(20);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_reassert: got %b want 1", in_ready); end
  endtask

  task automatic test_random_stall();
    toggle_done = 1'b0;
    fork
      begin
        int w;
        for (int i = 0; i < 200; i++) begin
          drive_beat($urandom_range(0, Q-1), $urandom_range(0, Q-1), $urandom_range(0, Q-1), w);
        end
        toggle_done = 1'b1;
      end
      begin
        while (!toggle_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain(50);
  endtask

  task automatic test_reset_midflight();
    int w;
    int pops0;
    out_ready = 1'b0;
    drive_beat(3, 5, 7, w);
    drive_beat(9, 2, 11, w);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    checks++; if ({out_x, out_y} !== '0) begin failures++; $display("FAIL mid_reset_data: got %h want 0", {out_x, out_y}); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_in_ready: got %b want 0", in_ready); end
    exp_q.delete();
    pops0 = pops;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (pops != pops0) begin failures++; $display("FAIL stale_beat: got %0d outputs want 0", pops - pops0); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
